// File: rtl/sync_fifo_level_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_level_buffer
//  Description : Single-clock FIFO with registered occupancy, programmable
//                almost-full / almost-empty levels, synchronous flush,
//                sticky overflow / underflow flags and selectable
//                first-word-fall-through or registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_level_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int FWFT       = 1,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            write_i,
   input  logic [DATA_WIDTH-1:0]           wr_data_i,
   input  logic                            read_i,
   input  logic                            flush_i,
   input  logic                            clear_err_i,
   output logic [DATA_WIDTH-1:0]           rd_data_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic                            almost_full_o,
   output logic                            almost_empty_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
   output logic                            overflow_o,
   output logic                            underflow_o
);

   // Pointer width guarded so an illegal depth still elaborates far enough
   // to reach the parameter checks below.
   localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(FIFO_DEPTH - 1);
   localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0] C_DEPTH    = C_CNT_W'(FIFO_DEPTH);
   localparam logic [C_CNT_W-1:0] C_AF       = C_CNT_W'(AF_LEVEL);
   localparam logic [C_CNT_W-1:0] C_AE       = C_CNT_W'(AE_LEVEL);

   // ------------------------------------------------------------------
   // Elaboration-time parameter legality
   // ------------------------------------------------------------------
   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_level_buffer: FIFO_DEPTH must be >= 2");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_bad_af
      $error("sync_fifo_level_buffer: AF_LEVEL must be in 1..FIFO_DEPTH");
   end
   if ((AE_LEVEL < 0) || (AE_LEVEL > FIFO_DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_level_buffer: AE_LEVEL must be in 0..FIFO_DEPTH-1");
   end
   if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
      $error("sync_fifo_level_buffer: FWFT must be 0 or 1");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [C_PTR_W-1:0]    r_wr_ptr;
   logic [C_PTR_W-1:0]    r_rd_ptr;
   logic [C_CNT_W-1:0]    r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [C_CNT_W-1:0]    w_count_nxt;

   // Flush masks both requests; full/empty gate acceptance from their
   // registered values so a full FIFO drops a write even alongside a read.
   assign w_wr_acc = write_i & ~r_full  & ~flush_i;
   assign w_rd_acc = read_i  & ~r_empty & ~flush_i;

   // Next occupancy: flush empties, otherwise +write -read.
   always_comb begin
      w_count_nxt = r_count;
      if (flush_i) begin
         w_count_nxt = '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + C_CNT_ONE;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = r_count - C_CNT_ONE;
      end
   end

   // Storage array: plain flops, contents deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   // Read/write pointers with explicit wrap at FIFO_DEPTH-1 (any depth).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + C_PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + C_PTR_ONE;
         end
      end
   end

   // Occupancy and all level flags registered together from next count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == C_DEPTH);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= C_AF);
         r_almost_empty <= (w_count_nxt <= C_AE);
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write_i && r_full) begin
            r_overflow <= 1'b1;
         end else if (clear_err_i) begin
            r_overflow <= 1'b0;
         end
         if (read_i && r_empty) begin
            r_underflow <= 1'b1;
         end else if (clear_err_i) begin
            r_underflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data path
   // ------------------------------------------------------------------
   if (FWFT != 0) begin : g_fwft
      // Head word visible combinationally while the FIFO is non-empty.
      assign rd_data_o = r_mem[r_rd_ptr];
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_rd_data;

      // Capture the head on an accepted read; hold otherwise.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            r_rd_data <= '0;
         end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
      end

      assign rd_data_o = r_rd_data;
   end

   assign count_o        = r_count;
   assign full_o         = r_full;
   assign empty_o        = r_empty;
   assign almost_full_o  = r_almost_full;
   assign almost_empty_o = r_almost_empty;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

endmodule
`default_nettype wire

// File: doc/sync_fifo_level_buffer.md
SYNC_FIFO_LEVEL_BUFFER -- requirements
Module: sync_fifo_level_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, words stored; any value >= 2, not limited to powers of two.
REQ-003 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read.
REQ-004 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2, almost-full threshold, range 1..FIFO_DEPTH.
REQ-005 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold, range 0..FIFO_DEPTH-1.
REQ-006 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port write_i, input, 1, write request.
REQ-009 SHALL have port wr_data_i, input, DATA_WIDTH, write data.
REQ-010 SHALL have port read_i, input, 1, read request.
REQ-011 SHALL have port flush_i, input, 1, synchronous discard of all contents.
REQ-012 SHALL have port clear_err_i, input, 1, clears sticky error flags.
REQ-013 SHALL have port rd_data_o, output, DATA_WIDTH, read data.
REQ-014 SHALL have ports full_o, empty_o, almost_full_o, almost_empty_o, output, 1 each, registered status.
REQ-015 SHALL have port count_o, output, $clog2(FIFO_DEPTH+1), registered occupancy.
REQ-016 SHALL have ports overflow_o, underflow_o, output, 1 each, sticky error flags.

Function
REQ-017 SHALL accept a write iff write_i=1, full_o=0 and flush_i=0; the word is stored at the write pointer and the pointer advances at that edge.
REQ-018 SHALL accept a read iff read_i=1, empty_o=0 and flush_i=0; the read pointer advances at that edge.
REQ-019 SHALL allow simultaneous accepted read and write; count_o is then unchanged, and full_o and empty_o keep their values.
REQ-020 SHALL, when full, reject a write in the same cycle as an accepted read; count becomes FIFO_DEPTH-1.
REQ-021 SHALL wrap each pointer from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH, with no aliasing for non-power-of-two depths.
REQ-022 SHALL update count_o as count + write_accepted - read_accepted each cycle.
REQ-023 SHALL derive every status output from the next count and register it with count_o, so all status changes in the same cycle as count_o:
- full_o = (count == FIFO_DEPTH)
- empty_o = (count == 0)
- almost_full_o = (count >= AF_LEVEL)
- almost_empty_o = (count <= AE_LEVEL)
REQ-024 SHALL, in FWFT=1, drive rd_data_o combinationally from the word at the read pointer; data is valid whenever empty_o=0 and the head word is visible before read_i is asserted.
REQ-025 SHALL, in FWFT=0, register rd_data_o with the head word at the edge of an accepted read (valid the following cycle), and hold rd_data_o otherwise, including during flush.
REQ-026 SHALL set overflow_o at the edge following any cycle with write_i=1 and full_o=1 (REQ-020 case included); it holds until cleared.
REQ-027 SHALL set underflow_o at the edge following any cycle with read_i=1 and empty_o=1; it holds until cleared.
REQ-028 SHALL clear both error flags when clear_err_i=1, with a set condition in the same cycle taking priority.
REQ-029 SHALL, on flush_i=1, ignore read_i and write_i in that cycle; at the next edge pointers=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=(AF_LEVEL==0 ? 1 : 0); error flags are unaffected.
REQ-030 SHALL implement storage as flip-flops with no reset on memory contents; no latches.
REQ-031 SHALL reject illegal parameters (FIFO_DEPTH<2, AF_LEVEL or AE_LEVEL out of range) with an elaboration-time error.

Reset
REQ-032 SHALL, on rst_n_i=0 and independent of the clock, drive pointers=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, and rd_data_o=0 in FWFT=0.
REQ-033 SHALL restart cleanly when reset is asserted mid-operation; the first write after reset release is read back first.

Verification
REQ-034 SHALL cover fill/drain: DEPTH=4, FWFT=1, write A,B,C,D -> full_o=1 and count_o=4 after the 4th edge; 4 reads return A,B,C,D in order; then empty_o=1.
REQ-035 SHALL cover wrap: DEPTH=5, 12 interleaved write/read pairs -> data in order, count_o stays at 1 after the first write, and no error flags set.
REQ-036 SHALL cover full with read+write: DEPTH=4 full, write_i=read_i=1 for one cycle -> head read, write dropped, count_o=3, overflow_o=1; clear_err_i -> overflow_o=0.
REQ-037 SHALL cover underflow and thresholds: read on empty -> underflow_o=1 and count_o=0; DEPTH=8, AF=6, AE=2 -> almost_full_o rises at count 6 and almost_empty_o falls at count 3.
REQ-038 SHALL cover FWFT=0 latency: write 0x55, read at cycle t -> rd_data_o=0x55 from t+1 and held after.
REQ-039 SHALL cover flush and reset: flush at count 3 with write_i=1 -> count_o=0, empty_o=1, nothing stored; async reset mid-burst -> all outputs per REQ-032 without a clock edge.
